// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, select codes and FSM types for the multicycle controller
package cpu_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AUIPC = 2'b11;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
  } class_t;

  typedef struct packed {
    class_t     cls;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       lb;
    logic       lbu;
    logic       illegal;
  } dec_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/inst_class_decode.sv
// rtl/inst_class_decode.sv - combinational opcode/funct3 classifier feeding the controller FSM
import cpu_ctrl_pkg::*;

module inst_class_decode (
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output dec_t       o_dec
);

  always_comb begin
    o_dec     = '0;
    o_dec.cls = CL_ALU;
    case (i_opcode)
      OP_R: o_dec.alu_op = ALU_FUNCT;
      OP_I: begin
        o_dec.alu_src = 1'b1;
        o_dec.alu_op  = ALU_FUNCT;
      end
      OP_LOAD: begin
        o_dec.cls     = CL_LOAD;
        o_dec.alu_src = 1'b1;
        case (i_funct3)
          3'b000:  o_dec.lb  = 1'b1;
          3'b010:  ;
          3'b100:  o_dec.lbu = 1'b1;
          default: o_dec.illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        o_dec.cls     = CL_STORE;
        o_dec.alu_src = 1'b1;
        o_dec.illegal = (i_funct3 != 3'b010);
      end
      OP_BRANCH: begin
        o_dec.cls     = CL_BRANCH;
        o_dec.alu_op  = ALU_BR;
        o_dec.illegal = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
      end
      OP_JAL: o_dec.cls = CL_JAL;
      OP_JALR: begin
        o_dec.cls     = CL_JALR;
        o_dec.alu_src = 1'b1;
        o_dec.illegal = (i_funct3 != 3'b000);
      end
      OP_LUI: begin
        o_dec.cls     = CL_LUI;
        o_dec.alu_src = 1'b1;
      end
      OP_AUIPC: begin
        o_dec.cls     = CL_AUIPC;
        o_dec.alu_src = 1'b1;
        o_dec.alu_op  = ALU_AUIPC;
      end
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXEC/MEM/WB sequencer issuing one-cycle datapath strobes
import cpu_ctrl_pkg::*;

module multicycle_controller #(
  parameter int                    IMEM_LAT   = 1,
  parameter int                    DMEM_LAT   = 1,
  parameter int                    IO_HI_BITS = 22,
  parameter logic [IO_HI_BITS-1:0] IO_BASE_HI = 22'h3FFFFF,
  parameter int                    IO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  input  logic        io_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        io_read,
  output logic        io_write,
  output logic        memio_to_reg,
  output logic        alu_src,
  output logic        lui,
  output logic        auipc,
  output logic        jump,
  output logic        jrn,
  output logic        lb,
  output logic        lbu,
  output logic [1:0]  alu_op,
  output logic [2:0]  branch_type,
  output logic        illegal,
  output logic        io_timeout,
  output logic [2:0]  state
);

  localparam int CNT_MAX = max3(IMEM_LAT, DMEM_LAT, IO_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  dec_t             r_dec, w_dec, w_f;
  logic [2:0]       r_f3, w_f3;
  logic             r_is_io, w_is_io, w_store, w_mem_done;
  logic             w_unused_bits;

  inst_class_decode u_dec (
    .i_opcode (inst[6:0]),
    .i_funct3 (inst[14:12]),
    .o_dec    (w_dec)
  );

  assign w_is_io       = (alu_result[31 -: IO_HI_BITS] == IO_BASE_HI);
  assign w_f           = (r_state == S_DECODE) ? w_dec : r_dec;
  assign w_f3          = (r_state == S_DECODE) ? inst[14:12] : r_f3;
  assign w_store       = (r_dec.cls == CL_STORE);
  assign state         = r_state;
  assign w_unused_bits = ^{inst[31:15], inst[11:7], alu_result};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_dec   <= '0;
      r_f3    <= '0;
      r_is_io <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      if (r_state == S_DECODE) begin
        r_dec <= w_dec;
        r_f3  <= inst[14:12];
      end
      // Region is fixed for the whole access, even if alu_result moves during MEM.
      if (r_state == S_EXEC) r_is_io <= w_is_io;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mem_done   = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SEQ;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    io_read      = 1'b0;
    io_write     = 1'b0;
    memio_to_reg = 1'b0;
    illegal      = 1'b0;
    io_timeout   = 1'b0;
    alu_src      = 1'b0;
    lui          = 1'b0;
    auipc        = 1'b0;
    jump         = 1'b0;
    jrn          = 1'b0;
    lb           = 1'b0;
    lbu          = 1'b0;
    alu_op       = ALU_ADD;
    branch_type  = 3'b000;
    // Reset low forces every output quiet even before the state register clears.
    if (rst_n) begin
      if (r_state != S_FETCH) begin
        alu_src     = w_f.alu_src;
        lui         = (w_f.cls == CL_LUI);
        auipc       = (w_f.cls == CL_AUIPC);
        jump        = (w_f.cls == CL_JAL) || (w_f.cls == CL_JALR);
        jrn         = (w_f.cls == CL_JALR);
        lb          = w_f.lb;
        lbu         = w_f.lbu;
        alu_op      = w_f.alu_op;
        branch_type = (w_f.cls == CL_BRANCH) ? w_f3 : 3'b000;
      end
      case (r_state)
        S_FETCH: begin
          if (r_cnt == CNT_W'(IMEM_LAT - 1)) begin
            ir_write = 1'b1;
            w_next   = S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_dec.illegal) begin
            illegal  = 1'b1;
            pc_write = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_dec.cls)
            CL_BRANCH: begin
              pc_write = 1'b1;
              pc_src   = branch_taken ? PC_REL : PC_SEQ;
              w_next   = S_FETCH;
            end
            CL_LOAD, CL_STORE: w_next = S_MEM;
            default:           w_next = S_WB;
          endcase
        end
        S_MEM: begin
          if (r_is_io) begin
            io_read    = !w_store;
            io_write   = w_store;
            w_mem_done = io_ready || (r_cnt == CNT_W'(IO_TIMEOUT - 1));
            io_timeout = !io_ready && (r_cnt == CNT_W'(IO_TIMEOUT - 1));
          end else begin
            mem_read   = !w_store;
            mem_write  = w_store;
            w_mem_done = (r_cnt == CNT_W'(DMEM_LAT - 1));
          end
          if (w_mem_done) begin
            pc_write = w_store;
            w_next   = w_store ? S_FETCH : S_WB;
          end
        end
        S_WB: begin
          reg_write    = 1'b1;
          memio_to_reg = (r_dec.cls == CL_LOAD);
          pc_write     = 1'b1;
          pc_src       = (r_dec.cls == CL_JAL)  ? PC_REL  :
                         (r_dec.cls == CL_JALR) ? PC_JALR : PC_SEQ;
          w_next       = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for the multicycle controller
module tb_multicycle_controller;

  localparam int IMEM_LAT   = 1;
  localparam int DMEM_LAT   = 2;
  localparam int IO_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        branch_taken = 1'b0;
  logic        io_ready = 1'b0;
  logic        ir_write, pc_write, reg_write, mem_read, mem_write, io_read, io_write;
  logic        memio_to_reg, alu_src, lui, auipc, jump, jrn, lb, lbu, illegal, io_timeout;
  logic [1:0]  pc_src, alu_op;
  logic [2:0]  branch_type, state;

  always #5 clk = ~clk;

  multicycle_controller #(
    .IMEM_LAT(IMEM_LAT), .DMEM_LAT(DMEM_LAT), .IO_HI_BITS(22),
    .IO_BASE_HI(22'h3FFFFF), .IO_TIMEOUT(IO_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .alu_result(alu_result),
    .branch_taken(branch_taken), .io_ready(io_ready), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
    .memio_to_reg(memio_to_reg), .alu_src(alu_src), .lui(lui), .auipc(auipc),
    .jump(jump), .jrn(jrn), .lb(lb), .lbu(lbu), .alu_op(alu_op),
    .branch_type(branch_type), .illegal(illegal), .io_timeout(io_timeout), .state(state)
  );

  typedef struct {
    int lat; int pc_src; int rw; int memio; int mr; int mw;
    int ior; int iow; int tmo; int ill; int chk_ctl; int alu_op; int btype;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] addr,
                                 input logic taken, input int ra);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [21:0] hi;
    bit         is_io, ok, tmo;
    int         acc;
    e  = '{default: 0};
    op = ins[6:0];
    f3 = ins[14:12];
    hi = addr[31:10];
    is_io = (hi == 22'h3FFFFF);
    tmo   = is_io && (ra == 0 || ra > IO_TIMEOUT);
    acc   = !is_io ? DMEM_LAT : (tmo ? IO_TIMEOUT : ra);
    ok    = 1'b1;
    e.rw  = 1;
    e.lat = IMEM_LAT + 3;
    case (op)
      7'h33, 7'h13: e.alu_op = 2;
      7'h37:        e.alu_op = 0;
      7'h17:        e.alu_op = 3;
      7'h6F:        e.pc_src = 1;
      7'h67: begin ok = (f3 == 3'd0); e.pc_src = 2; end
      7'h63: begin
        ok = (f3 != 3'd2) && (f3 != 3'd3);
        e.rw = 0; e.alu_op = 1; e.btype = f3; e.lat = IMEM_LAT + 2; e.pc_src = taken ? 1 : 0;
      end
      7'h03: begin
        ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd4);
        e.memio = 1; e.lat = IMEM_LAT + 3 + acc; e.tmo = tmo;
        if (is_io) e.ior = acc; else e.mr = acc;
      end
      7'h23: begin
        ok = (f3 == 3'd2);
        e.rw = 0; e.lat = IMEM_LAT + 2 + acc; e.tmo = tmo;
        if (is_io) e.iow = acc; else e.mw = acc;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) e = '{lat: IMEM_LAT + 1, ill: 1, default: 0};
    else     e.chk_ctl = 1;
    return e;
  endfunction

  // MMIO peripheral: raises io_ready in the ready_after-th strobe cycle (0 = never)
  int ready_after = 0;
  int io_seen = 0;
  bit stray = 1'b0;
  always @(posedge clk) begin
    #1;
    if (io_read || io_write) begin
      io_seen++;
      io_ready = (ready_after != 0) && (io_seen == ready_after);
    end else begin
      io_seen  = 0;
      io_ready = stray;
    end
  end

  int cyc, c_ir, c_rwcyc, c_rw, c_memio, c_mr, c_mw, c_ior, c_iow, c_tmo, c_ill;
  exp_t e_cur;

  task automatic clear_counts();
    cyc = 0; c_ir = 0; c_rwcyc = 0; c_rw = 0; c_memio = 0; c_mr = 0; c_mw = 0;
    c_ior = 0; c_iow = 0; c_tmo = 0; c_ill = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      clear_counts();
    end else begin
      cyc++;
      c_ir  += int'(ir_write);  c_mr  += int'(mem_read); c_mw  += int'(mem_write);
      c_ior += int'(io_read);   c_iow += int'(io_write); c_tmo += int'(io_timeout);
      c_ill += int'(illegal);
      if (reg_write) begin
        c_rw++;
        c_rwcyc = cyc;
        c_memio = int'(memio_to_reg);
        check("rw_excl", {31'd0, mem_write | io_write}, 0);
      end
      if (pc_write) begin
        if (sb.size() == 0) begin
          check("unexp_pc_write", 1, 0);
        end else begin
          e_cur = sb.pop_front();
          check("latency", cyc, e_cur.lat);
          check("ir_write", c_ir, 1);
          check("pc_src", {30'd0, pc_src}, e_cur.pc_src);
          check("reg_write", c_rw, e_cur.rw);
          if (e_cur.rw != 0) begin
            check("rw_cycle", c_rwcyc, e_cur.lat);
            check("memio_to_reg", c_memio, e_cur.memio);
          end
          check("mem_read", c_mr, e_cur.mr);
          check("mem_write", c_mw, e_cur.mw);
          check("io_read", c_ior, e_cur.ior);
          check("io_write", c_iow, e_cur.iow);
          check("io_timeout", c_tmo, e_cur.tmo);
          check("illegal", c_ill, e_cur.ill);
          if (e_cur.chk_ctl != 0) begin
            check("alu_op", {30'd0, alu_op}, e_cur.alu_op);
            check("branch_type", {29'd0, branch_type}, e_cur.btype);
          end
        end
        clear_counts();
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] addr, input logic taken,
                       input int ra, input bit stray_i);
    bit done;
    inst = ins; alu_result = addr; branch_taken = taken;
    ready_after = ra; stray = stray_i;
    sb.push_back(model(ins, addr, taken, ra));
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk); #1;
      done = (sb.size() == 0);
    end
    check("instr_done", {31'd0, done}, 1);
    check("fetch_after", {29'd0, state}, 0);
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {22'd0, ir_write, pc_write, reg_write, mem_read, mem_write,
                io_read, io_write, illegal, io_timeout, memio_to_reg}, 0);
    check({tag, "_state"}, {29'd0, state}, 0);
  endtask

  initial begin
    clear_counts();
    inst = 32'h0000007F; alu_result = 32'hFFFFFC70;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    rst_n = 1'b1;

    issue(32'h002081B3, 32'h0, 1'b0, 0, 1'b1);  // add x3,x1,x2 with stray io_ready
    issue(32'h00208463, 32'h0, 1'b1, 0, 1'b0);  // beq taken
    issue(32'h00208463, 32'h0, 1'b0, 0, 1'b0);  // beq not taken
    issue(32'h00209463, 32'h0, 1'b1, 0, 1'b0);  // bne taken
    issue(32'h00202823, 32'h00000010, 1'b0, 0, 1'b0);  // sw ram
    issue(32'h01002183, 32'h00000010, 1'b0, 0, 1'b1);  // lw ram, stray io_ready
    issue(32'h01002183, 32'hFFFFFBFC, 1'b0, 3, 1'b0);  // just below mmio window
    issue(32'h01002183, 32'hFFFFFC70, 1'b0, 5, 1'b0);  // lw mmio, ready after 5
    issue(32'h00202823, 32'hFFFFFC60, 1'b0, 0, 1'b0);  // sw mmio, timeout
    issue(32'h00202823, 32'hFFFFFC60, 1'b0, IO_TIMEOUT, 1'b0);  // ready on last cycle
    issue(32'h00000183, 32'hFFFFFFFC, 1'b0, 1, 1'b0);  // lb mmio, immediate ready
    issue(32'h00004183, 32'hFFFFFC00, 1'b0, 0, 1'b0);  // lbu mmio, timeout
    issue(32'h008000EF, 32'h0, 1'b0, 0, 1'b0);  // jal
    issue(32'h000100E7, 32'h0, 1'b0, 0, 1'b0);  // jalr
    issue(32'h123451B7, 32'h0, 1'b0, 0, 1'b0);  // lui
    issue(32'h00001197, 32'h0, 1'b0, 0, 1'b0);  // auipc
    issue(32'h00108093, 32'h0, 1'b0, 0, 1'b0);  // addi
    issue(32'h0000007F, 32'h0, 1'b0, 0, 1'b0);  // illegal opcode
    issue(32'h00003183, 32'h0, 1'b0, 0, 1'b0);  // illegal load funct3
    issue(32'h0020A463, 32'h0, 1'b0, 0, 1'b0);  // illegal branch funct3

    // Reset in the middle of an MMIO wait
    inst = 32'h01002183; alu_result = 32'hFFFFFC70; ready_after = 0; stray = 1'b0;
    sb.push_back(model(inst, alu_result, 1'b0, 0));
    repeat (6) @(posedge clk);
    #1 check("in_mmio_wait", {31'd0, io_read}, 1);
    rst_n = 1'b0;
    @(posedge clk); #1 check_quiet("mid_mmio_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    issue(32'h002081B3, 32'h0, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
